// File: rtl/cpu_pkg.sv
// Shared types and constants for the multi-cycle accumulator CPU control path.
// Opcode classes are taken from the top nibble of the instruction register.
package cpu_pkg;

    localparam int unsigned CPU_ADDR_W  = 5;
    localparam int unsigned CPU_INSTR_W = 16;
    localparam int unsigned CPU_CNT_W   = 8;

    localparam logic [3:0] OP_JC   = 4'hD;
    localparam logic [3:0] OP_JMP  = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        EXECUTE,
        WRITEBACK,
        HALTED
    } state_t;

    function automatic logic is_ctrl_op(input logic [3:0] op);
        return (op == OP_JMP) || (op == OP_JC);
    endfunction

endpackage

// File: rtl/seq_pc_unit.sv
// Program counter with clear / load-target / wrapping increment, plus the
// saturating retired-instruction counter.
module seq_pc_unit
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W = CPU_ADDR_W,
    parameter int unsigned CNT_W  = CPU_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pc_clr,
    input  logic              pc_load,
    input  logic              pc_inc,
    input  logic [ADDR_W-1:0] target,
    input  logic              cnt_inc,
    output logic [ADDR_W-1:0] pc,
    output logic [CNT_W-1:0]  retired
);

    // Increment wraps naturally at 2**ADDR_W.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc <= '0;
        end else if (pc_clr) begin
            pc <= '0;
        end else if (pc_load) begin
            pc <= target;
        end else if (pc_inc) begin
            pc <= pc + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            retired <= '0;
        end else if (cnt_inc && (retired != '1)) begin
            retired <= retired + 1'b1;
        end
    end

endmodule

// File: rtl/cpu_sequencer.sv
// FETCH/DECODE/EXECUTE/WRITEBACK control unit: owns IR and carry, resolves
// JMP/JC/HALT internally and gates the decoder's datapath enables by phase.
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W  = CPU_ADDR_W,
    parameter int unsigned INSTR_W = CPU_INSTR_W,
    parameter int unsigned CNT_W   = CPU_CNT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               step_mode,
    input  logic               step,
    input  logic [INSTR_W-1:0] instr_i,
    input  logic               dec_alu_ce_i,
    input  logic               dec_a_we_i,
    input  logic               dec_rf_we_i,
    input  logic               carry_we_i,
    input  logic               carry_i,
    output logic [ADDR_W-1:0]  pc_o,
    output logic [INSTR_W-1:0] ir_o,
    output logic               alu_ce_o,
    output logic               a_we_o,
    output logic               rf_we_o,
    output logic               carry_o,
    output logic               busy_o,
    output logic               halted_o,
    output logic [CNT_W-1:0]   retired_o
);

    state_t state, state_next;

    logic [3:0] opcode;
    logic       is_jmp, is_jc, is_halt, is_ctrl, jump_taken;
    logic       ir_load, carry_load, carry_clr;
    logic       pc_clr, pc_load, pc_inc, cnt_inc;

    assign opcode     = ir_o[INSTR_W-1 -: 4];
    assign is_jmp     = (opcode == OP_JMP);
    assign is_jc      = (opcode == OP_JC);
    assign is_halt    = (opcode == OP_HALT);
    assign is_ctrl    = is_ctrl_op(opcode);
    assign jump_taken = is_jmp || (is_jc && carry_o);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ir_o <= '0;
        end else if (ir_load) begin
            ir_o <= instr_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            carry_o <= 1'b0;
        end else if (carry_clr) begin
            carry_o <= 1'b0;
        end else if (carry_load) begin
            carry_o <= carry_i;
        end
    end

    // Enables are decoded from the registered state only, so an async reset
    // drops them in the same cycle it is asserted.
    always_comb begin
        state_next = state;
        alu_ce_o   = 1'b0;
        a_we_o     = 1'b0;
        rf_we_o    = 1'b0;
        busy_o     = 1'b0;
        halted_o   = 1'b0;
        ir_load    = 1'b0;
        carry_load = 1'b0;
        carry_clr  = 1'b0;
        pc_clr     = 1'b0;
        pc_load    = 1'b0;
        pc_inc     = 1'b0;
        cnt_inc    = 1'b0;

        unique case (state)
            IDLE: begin
                if (step_mode ? step : start) begin
                    state_next = FETCH;
                end
            end
            FETCH: begin
                busy_o     = 1'b1;
                ir_load    = 1'b1;
                state_next = DECODE;
            end
            DECODE: begin
                busy_o = 1'b1;
                if (is_halt) begin
                    cnt_inc    = 1'b1;
                    state_next = HALTED;
                end else if (is_ctrl) begin
                    state_next = WRITEBACK;
                end else begin
                    state_next = EXECUTE;
                end
            end
            EXECUTE: begin
                busy_o     = 1'b1;
                alu_ce_o   = dec_alu_ce_i;
                carry_load = carry_we_i;
                state_next = WRITEBACK;
            end
            WRITEBACK: begin
                busy_o     = 1'b1;
                a_we_o     = dec_a_we_i && !is_ctrl;
                rf_we_o    = dec_rf_we_i && !is_ctrl;
                pc_load    = jump_taken;
                pc_inc     = !jump_taken;
                cnt_inc    = 1'b1;
                state_next = step_mode ? IDLE : FETCH;
            end
            HALTED: begin
                halted_o = 1'b1;
                if (start) begin
                    pc_clr     = 1'b1;
                    carry_clr  = 1'b1;
                    state_next = FETCH;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    seq_pc_unit #(
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) u_pc (
        .clk     (clk),
        .rst     (rst),
        .pc_clr  (pc_clr),
        .pc_load (pc_load),
        .pc_inc  (pc_inc),
        .target  (ir_o[ADDR_W-1:0]),
        .cnt_inc (cnt_inc),
        .pc      (pc_o),
        .retired (retired_o)
    );

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: small program memory and a toy decoder
// (bits 8..11 of the instruction drive a_we/rf_we/carry_we/carry_i).
module tb_cpu_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        step_mode = 1'b0;
    logic        step = 1'b0;
    logic [15:0] instr_i;
    logic        dec_alu_ce_i, dec_a_we_i, dec_rf_we_i, carry_we_i, carry_i;
    logic [4:0]  pc_o;
    logic [15:0] ir_o;
    logic        alu_ce_o, a_we_o, rf_we_o, carry_o, busy_o, halted_o;
    logic [7:0]  retired_o;

    logic [15:0] mem [32];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc, alun, an, rfn;

    always #5 clk = ~clk;

    assign instr_i      = mem[pc_o];
    assign dec_alu_ce_i = 1'b1;
    assign dec_a_we_i   = ir_o[8];
    assign dec_rf_we_i  = ir_o[9];
    assign carry_we_i   = ir_o[10];
    assign carry_i      = ir_o[11];

    cpu_sequencer #(
        .ADDR_W  (5),
        .INSTR_W (16),
        .CNT_W   (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .step_mode    (step_mode),
        .step         (step),
        .instr_i      (instr_i),
        .dec_alu_ce_i (dec_alu_ce_i),
        .dec_a_we_i   (dec_a_we_i),
        .dec_rf_we_i  (dec_rf_we_i),
        .carry_we_i   (carry_we_i),
        .carry_i      (carry_i),
        .pc_o         (pc_o),
        .ir_o         (ir_o),
        .alu_ce_o     (alu_ce_o),
        .a_we_o       (a_we_o),
        .rf_we_o      (rf_we_o),
        .carry_o      (carry_o),
        .busy_o       (busy_o),
        .halted_o     (halted_o),
        .retired_o    (retired_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch one instruction with start or step, then run until busy drops.
    task automatic run_one(input logic use_step, input logic extra_step,
                           output int c, output int alu_n, output int a_n, output int rf_n);
        c = 0; alu_n = 0; a_n = 0; rf_n = 0;
        if (use_step) step = 1'b1; else start = 1'b1;
        tick();
        step = 1'b0;
        start = 1'b0;
        check("launch_busy", 32'(busy_o), 32'd1);
        for (int k = 0; k < 10; k++) begin
            step = (extra_step && k == 1);
            tick();
            c++;
            alu_n += int'(alu_ce_o);
            a_n   += int'(a_we_o);
            rf_n  += int'(rf_we_o);
            if (!busy_o) break;
        end
        step = 1'b0;
        check("run_done", 32'(busy_o), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 16'h0000;

        // Reset values
        #23;
        check("rst_pc", 32'(pc_o), 32'd0);
        check("rst_ir", 32'(ir_o), 32'd0);
        check("rst_carry", 32'(carry_o), 32'd0);
        check("rst_retired", 32'(retired_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_halted", 32'(halted_o), 32'd0);
        rst = 1'b1;
        tick();

        // Free-running: three datapath ops with a_we, then HALT at addr 3
        mem[0] = 16'h0100; mem[1] = 16'h0100; mem[2] = 16'h0100; mem[3] = 16'hF000;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            check($sformatf("free_awe_%0d", i), 32'(a_we_o), ((i % 4) == 3) ? 32'd1 : 32'd0);
            if ((i % 4) == 0) check($sformatf("free_pc_%0d", i), 32'(pc_o), 32'(i / 4));
        end
        check("free_retired", 32'(retired_o), 32'd3);
        tick();
        tick();
        check("halt_flag", 32'(halted_o), 32'd1);
        check("halt_busy", 32'(busy_o), 32'd0);
        check("halt_pc", 32'(pc_o), 32'd3);
        check("halt_retired", 32'(retired_o), 32'd4);

        // Single-step program exercising JC/JMP/carry/wrap
        mem[0]  = 16'h0400;
        mem[1]  = 16'hDF1F;
        mem[2]  = 16'hEF14;
        mem[20] = 16'h0C00;
        mem[21] = 16'hDF1E;
        mem[30] = 16'h0300;
        mem[31] = 16'h0100;
        step_mode = 1'b1;

        run_one(1'b0, 1'b0, cyc, alun, an, rfn);
        check("i0_cyc", 32'(cyc), 32'd4);
        check("i0_pc", 32'(pc_o), 32'd1);
        check("i0_carry", 32'(carry_o), 32'd0);
        check("i0_alu", 32'(alun), 32'd1);

        run_one(1'b1, 1'b0, cyc, alun, an, rfn);
        check("jc_nt_cyc", 32'(cyc), 32'd3);
        check("jc_nt_pc", 32'(pc_o), 32'd2);
        check("jc_nt_en", 32'(alun + an + rfn), 32'd0);

        run_one(1'b1, 1'b0, cyc, alun, an, rfn);
        check("jmp_cyc", 32'(cyc), 32'd3);
        check("jmp_pc", 32'(pc_o), 32'd20);
        check("jmp_en", 32'(alun + an + rfn), 32'd0);
        check("jmp_carry", 32'(carry_o), 32'd0);

        run_one(1'b1, 1'b0, cyc, alun, an, rfn);
        check("setc_carry", 32'(carry_o), 32'd1);
        check("setc_pc", 32'(pc_o), 32'd21);

        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("start_in_step_busy", 32'(busy_o), 32'd0);
        check("start_in_step_pc", 32'(pc_o), 32'd21);

        run_one(1'b1, 1'b1, cyc, alun, an, rfn);
        check("jc_t_cyc", 32'(cyc), 32'd3);
        check("jc_t_pc", 32'(pc_o), 32'd30);
        check("jc_t_carry", 32'(carry_o), 32'd1);
        tick();
        check("busy_step_ignored", 32'(busy_o), 32'd0);

        run_one(1'b1, 1'b0, cyc, alun, an, rfn);
        check("dp_cyc", 32'(cyc), 32'd4);
        check("dp_awe", 32'(an), 32'd1);
        check("dp_rfwe", 32'(rfn), 32'd1);
        check("dp_pc", 32'(pc_o), 32'd31);

        run_one(1'b1, 1'b0, cyc, alun, an, rfn);
        check("wrap_pc", 32'(pc_o), 32'd0);
        check("wrap_retired", 32'(retired_o), 32'd11);

        mem[0] = 16'hEF1F;
        run_one(1'b1, 1'b0, cyc, alun, an, rfn);
        check("to31_pc", 32'(pc_o), 32'd31);
        mem[31] = 16'hF000;
        run_one(1'b1, 1'b0, cyc, alun, an, rfn);
        check("halt31_cyc", 32'(cyc), 32'd2);
        check("halt31_flag", 32'(halted_o), 32'd1);
        check("halt31_pc", 32'(pc_o), 32'd31);
        check("halt31_retired", 32'(retired_o), 32'd13);

        mem[0] = 16'hEF05;
        run_one(1'b0, 1'b0, cyc, alun, an, rfn);
        check("restart_pc", 32'(pc_o), 32'd5);
        check("restart_carry", 32'(carry_o), 32'd0);
        check("restart_halted", 32'(halted_o), 32'd0);
        check("restart_retired", 32'(retired_o), 32'd14);

        // Reset while in EXECUTE with alu_ce asserted
        mem[5] = 16'h0100;
        step = 1'b1;
        tick();
        step = 1'b0;
        tick();
        tick();
        check("exec_alu", 32'(alu_ce_o), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("arst_alu", 32'(alu_ce_o), 32'd0);
        check("arst_awe", 32'(a_we_o), 32'd0);
        check("arst_busy", 32'(busy_o), 32'd0);
        tick();
        rst = 1'b1;
        tick();
        check("arst_pc", 32'(pc_o), 32'd0);
        check("arst_ir", 32'(ir_o), 32'd0);
        check("arst_retired", 32'(retired_o), 32'd0);
        check("arst_idle", 32'(busy_o), 32'd0);

        // Retired counter saturation with a JMP-to-self loop
        step_mode = 1'b0;
        mem[0] = 16'hE000;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (600) tick();
        check("ret_200", 32'(retired_o), 32'd200);
        repeat (300) tick();
        check("ret_sat", 32'(retired_o), 32'd255);
        check("loop_busy", 32'(busy_o), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
